// File: rtl/gpio_axi_lite_pkg.sv
// gpio_axi_lite_pkg: register map, ID value and response code shared by the GPIO block.
package gpio_axi_lite_pkg;
    // Register word index, i.e. byte offset >> 2
    typedef enum logic [3:0] {
        REG_VERSION = 4'h0,
        REG_CONTROL = 4'h1,
        REG_DIR     = 4'h2,
        REG_OUT     = 4'h3,
        REG_IN      = 4'h4,
        REG_MASK    = 4'h5,
        REG_EDGE    = 4'h6,
        REG_POL     = 4'h7,
        REG_STATUS  = 4'h8
    } reg_e;
    localparam logic [31:0] VERSION   = 32'h2025_0910;
    localparam logic [1:0]  RESP_OKAY = 2'b00;
endpackage

// File: rtl/gpio_sync.sv
// gpio_sync: parameterized-width two-flop synchronizer for asynchronous pad inputs.
module gpio_sync #(
    parameter int P_WIDTH = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [P_WIDTH-1:0] i_d,
    output logic [P_WIDTH-1:0] o_q
);
    logic [P_WIDTH-1:0] r_meta;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= '0;
            o_q    <= '0;
        end else begin
            r_meta <= i_d;
            o_q    <= r_meta;
        end
    end
endmodule

// File: rtl/gpio_axi_lite.sv
// gpio_axi_lite: AXI4-Lite GPIO with per-bit direction, edge/level interrupts and W1C status.
module gpio_axi_lite
    import gpio_axi_lite_pkg::*;
#(
    parameter int P_WIDTH = 32
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic [31:0]        s_axi_lite_awaddr,
    input  logic               s_axi_lite_awvalid,
    output logic               s_axi_lite_awready,
    input  logic [31:0]        s_axi_lite_wdata,
    input  logic               s_axi_lite_wvalid,
    output logic               s_axi_lite_wready,
    output logic [1:0]         s_axi_lite_bresp,
    output logic               s_axi_lite_bvalid,
    input  logic               s_axi_lite_bready,
    input  logic [31:0]        s_axi_lite_araddr,
    input  logic               s_axi_lite_arvalid,
    output logic               s_axi_lite_arready,
    output logic [31:0]        s_axi_lite_rdata,
    output logic [1:0]         s_axi_lite_rresp,
    output logic               s_axi_lite_rvalid,
    input  logic               s_axi_lite_rready,
    input  logic [P_WIDTH-1:0] gpio_in,
    output logic [P_WIDTH-1:0] gpio_out,
    output logic [P_WIDTH-1:0] gpio_dir,
    output logic               interrupt
);
    logic [P_WIDTH-1:0] r_dir, r_out, r_mask, r_edge, r_pol, r_status, r_prev;
    logic [P_WIDTH-1:0] w_sync, w_evt, w_clr;
    logic               r_ie, r_irq, r_awready, r_bvalid, r_arready, r_rvalid;
    logic [31:0]        r_rdata, w_rdata;
    logic [3:0]         w_widx, w_ridx;
    logic               w_wr, w_rd, w_unused;

    gpio_sync #(.P_WIDTH(P_WIDTH)) u_sync (
        .i_clk   (aclk),
        .i_rst_n (aresetn),
        .i_d     (gpio_in),
        .o_q     (w_sync)
    );

    assign w_widx = s_axi_lite_awaddr[5:2];
    assign w_ridx = s_axi_lite_araddr[5:2];
    assign w_wr   = r_awready & s_axi_lite_awvalid & s_axi_lite_wvalid;
    assign w_rd   = r_arready & s_axi_lite_arvalid;
    assign w_clr  = (w_wr && w_widx == REG_STATUS) ? s_axi_lite_wdata[P_WIDTH-1:0] : '0;
    // Only input-direction bits can raise events
    assign w_evt  = r_dir & ((r_edge & r_pol & w_sync & ~r_prev)
                           | (r_edge & ~r_pol & ~w_sync & r_prev)
                           | (~r_edge & ~(w_sync ^ r_pol)));
    assign w_unused = &{1'b0, s_axi_lite_awaddr[31:6], s_axi_lite_awaddr[1:0],
                        s_axi_lite_araddr[31:6], s_axi_lite_araddr[1:0], s_axi_lite_wdata};

    always_comb begin
        w_rdata = '0;
        case (w_ridx)
            REG_VERSION: w_rdata = VERSION;
            REG_CONTROL: w_rdata[0] = r_ie;
            REG_DIR:     w_rdata[P_WIDTH-1:0] = r_dir;
            REG_OUT:     w_rdata[P_WIDTH-1:0] = r_out;
            REG_IN:      w_rdata[P_WIDTH-1:0] = w_sync;
            REG_MASK:    w_rdata[P_WIDTH-1:0] = r_mask;
            REG_EDGE:    w_rdata[P_WIDTH-1:0] = r_edge;
            REG_POL:     w_rdata[P_WIDTH-1:0] = r_pol;
            REG_STATUS:  w_rdata[P_WIDTH-1:0] = r_status;
            default:     w_rdata = '0;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_dir    <= '1;
            r_out    <= '0;
            r_mask   <= '0;
            r_edge   <= '0;
            r_pol    <= '0;
            r_status <= '0;
            r_prev   <= '0;
            r_ie     <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr) begin
                case (w_widx)
                    REG_CONTROL: r_ie   <= s_axi_lite_wdata[0];
                    REG_DIR:     r_dir  <= s_axi_lite_wdata[P_WIDTH-1:0];
                    REG_OUT:     r_out  <= s_axi_lite_wdata[P_WIDTH-1:0];
                    REG_MASK:    r_mask <= s_axi_lite_wdata[P_WIDTH-1:0];
                    REG_EDGE:    r_edge <= s_axi_lite_wdata[P_WIDTH-1:0];
                    REG_POL:     r_pol  <= s_axi_lite_wdata[P_WIDTH-1:0];
                    default: ;
                endcase
            end
            r_status <= (r_status & ~w_clr) | w_evt;
            r_prev   <= w_sync;
            r_irq    <= r_ie & |(r_status & r_mask);
        end
    end

    // Ready pulses for one cycle; the handshake edge is the one where it is high
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_awready <= 1'b0;
            r_bvalid  <= 1'b0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_awready <= !r_awready && s_axi_lite_awvalid && s_axi_lite_wvalid && !r_bvalid;
            r_bvalid  <= w_wr | (r_bvalid & ~s_axi_lite_bready);
            r_arready <= !r_arready && s_axi_lite_arvalid && !r_rvalid;
            r_rvalid  <= w_rd | (r_rvalid & ~s_axi_lite_rready);
            if (w_rd) r_rdata <= w_rdata;
        end
    end

    assign s_axi_lite_awready = r_awready;
    assign s_axi_lite_wready  = r_awready;
    assign s_axi_lite_bvalid  = r_bvalid;
    assign s_axi_lite_bresp   = RESP_OKAY;
    assign s_axi_lite_arready = r_arready;
    assign s_axi_lite_rvalid  = r_rvalid;
    assign s_axi_lite_rdata   = r_rdata;
    assign s_axi_lite_rresp   = RESP_OKAY;
    assign gpio_dir           = r_dir;
    assign gpio_out           = r_out;
    assign interrupt          = r_irq;
endmodule

// File: tb/tb_gpio_axi_lite.sv
// tb_gpio_axi_lite: randomized and directed AXI-Lite traffic checked against a behavioural GPIO model.
module tb_gpio_axi_lite;
    localparam int W = 32;
    logic         aclk = 1'b0, aresetn = 1'b0;
    logic [31:0]  awaddr = '0, wdata = '0, araddr = '0;
    logic         awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic         awready, wready, bvalid, arready, rvalid, interrupt;
    logic [1:0]   bresp, rresp;
    logic [31:0]  rdata;
    logic [W-1:0] gpio_in, gpio_out, gpio_dir;
    logic [W-1:0] ext = '1;
    int           n_chk = 0, n_err = 0;

    // Pads: output-direction bits loop back, input bits see the external drive (pull-ups by default)
    assign gpio_in = (gpio_dir & ext) | (~gpio_dir & gpio_out);

    gpio_axi_lite #(.P_WIDTH(W)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_lite_awaddr(awaddr), .s_axi_lite_awvalid(awvalid), .s_axi_lite_awready(awready),
        .s_axi_lite_wdata(wdata), .s_axi_lite_wvalid(wvalid), .s_axi_lite_wready(wready),
        .s_axi_lite_bresp(bresp), .s_axi_lite_bvalid(bvalid), .s_axi_lite_bready(bready),
        .s_axi_lite_araddr(araddr), .s_axi_lite_arvalid(arvalid), .s_axi_lite_arready(arready),
        .s_axi_lite_rdata(rdata), .s_axi_lite_rresp(rresp), .s_axi_lite_rvalid(rvalid),
        .s_axi_lite_rready(rready),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_dir(gpio_dir), .interrupt(interrupt)
    );

    always #5 aclk = ~aclk;

    logic [W-1:0] m_dir, m_out, m_mask, m_edge, m_pol, m_status, m_evt;
    logic         m_ie, m_irq;
    logic [W-1:0] q_pad[$];

    task automatic m_reset();
        m_dir = '1; m_out = '0; m_mask = '0; m_edge = '0; m_pol = '0;
        m_status = '0; m_evt = '0; m_ie = 1'b0; m_irq = 1'b0;
        q_pad.delete();
        repeat (3) q_pad.push_back('0);
    endtask

    // Pad history: q_pad[1] is the synchronized value, q_pad[0] its predecessor
    always @(posedge aclk) begin : p_model
        logic [W-1:0] s, p;
        if (aresetn) begin
            s = q_pad[1];
            p = q_pad[0];
            m_evt = m_dir & ((m_edge & m_pol & s & ~p) | (m_edge & ~m_pol & ~s & p)
                           | (~m_edge & ~(s ^ m_pol)));
            m_irq = m_ie & (|(m_status & m_mask));
            m_status = m_status | m_evt;
            q_pad.push_back((m_dir & ext) | (~m_dir & m_out));
            void'(q_pad.pop_front());
        end
    end

    function automatic logic [31:0] mread(input logic [3:0] i);
        case (i)
            4'h0: return 32'h2025_0910;
            4'h1: return {31'b0, m_ie};
            4'h2: return m_dir;
            4'h3: return m_out;
            4'h4: return q_pad[1];
            4'h5: return m_mask;
            4'h6: return m_edge;
            4'h7: return m_pol;
            4'h8: return m_status;
            default: return 32'h0;
        endcase
    endfunction

    task automatic mwrite(input logic [3:0] i, input logic [31:0] d);
        case (i)
            4'h1: m_ie = d[0];
            4'h2: m_dir = d;
            4'h3: m_out = d;
            4'h5: m_mask = d;
            4'h6: m_edge = d;
            4'h7: m_pol = d;
            4'h8: m_status = (m_status & ~d) | m_evt;
            default: ;
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input int hold);
        int t = 0;
        awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
        do begin @(negedge aclk); t++; end while (!(awready && wready) && t < 20);
        chk("aw_ready", {31'b0, awready & wready}, 1);
        if (!(awready && wready)) begin awvalid = 1'b0; wvalid = 1'b0; return; end
        @(posedge aclk); #1 mwrite(a[5:2], d);
        @(negedge aclk); awvalid = 1'b0; wvalid = 1'b0;
        chk("bvalid", {31'b0, bvalid}, 1);
        chk("bresp", {30'b0, bresp}, 0);
        if (hold > 0) begin
            awvalid = 1'b1; wvalid = 1'b1;
            repeat (hold) begin
                @(negedge aclk);
                chk("bvalid_hold", {31'b0, bvalid}, 1);
                chk("awready_hold", {31'b0, awready}, 0);
            end
            awvalid = 1'b0; wvalid = 1'b0;
        end
        bready = 1'b1;
        @(negedge aclk); bready = 1'b0;
        chk("bvalid_clr", {31'b0, bvalid}, 0);
    endtask

    task automatic axi_read(input logic [31:0] a, input int hold, output logic [31:0] d);
        int t = 0;
        logic [31:0] exp;
        d = '0;
        araddr = a; arvalid = 1'b1;
        do begin @(negedge aclk); t++; end while (!arready && t < 20);
        chk("ar_ready", {31'b0, arready}, 1);
        if (!arready) begin arvalid = 1'b0; return; end
        exp = mread(a[5:2]);
        @(negedge aclk); arvalid = 1'b0;
        chk("rvalid", {31'b0, rvalid}, 1);
        chk("rresp", {30'b0, rresp}, 0);
        chk($sformatf("rdata@%h", a[7:0]), rdata, exp);
        d = rdata;
        if (hold > 0) begin
            arvalid = 1'b1;
            repeat (hold) begin
                @(negedge aclk);
                chk("rvalid_hold", {31'b0, rvalid}, 1);
                chk("arready_hold", {31'b0, arready}, 0);
                chk("rdata_hold", rdata, exp);
            end
            arvalid = 1'b0;
        end
        rready = 1'b1;
        @(negedge aclk); rready = 1'b0;
        chk("rvalid_clr", {31'b0, rvalid}, 0);
    endtask

    task automatic do_reset();
        @(negedge aclk);
        aresetn = 1'b0; m_reset();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
        repeat (2) @(negedge aclk);
        chk("rst_ready", {29'b0, awready, wready, arready}, 0);
        chk("rst_valid", {30'b0, bvalid, rvalid}, 0);
        chk("rst_irq", {31'b0, interrupt}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_dir", gpio_dir, 32'hFFFF_FFFF);
        chk("rst_out", gpio_out, 0);
        aresetn = 1'b1;
    endtask

    initial begin
        logic [31:0] d, a;
        logic [3:0]  idx;
        int          op, t;
        do_reset();
        repeat (3) @(negedge aclk);
        axi_read(32'h08, 0, d); chk("dir_rst", d, 32'hFFFF_FFFF);
        axi_read(32'h0C, 0, d); chk("out_rst", d, 0);
        axi_read(32'h10, 0, d); chk("in_pullup", d, 32'hFFFF_FFFF);
        axi_read(32'h00, 0, d); chk("version", d, 32'h2025_0910);

        axi_write(32'h08, 32'h0, 0);
        axi_write(32'h0C, 32'hA5A5_5A5A, 0);
        repeat (3) @(negedge aclk);
        axi_read(32'h10, 0, d); chk("in_loop", d, 32'hA5A5_5A5A);

        axi_write(32'h0C, 32'hA5A5_5A5A, 5);
        axi_read(32'h0C, 5, d);

        do_reset();
        axi_write(32'h08, 32'hFFFF_FFFF, 0);
        axi_write(32'h18, 32'hFFFF_FFFF, 0);
        axi_write(32'h1C, 32'h0, 0);
        axi_write(32'h14, 32'h1, 0);
        axi_write(32'h04, 32'h1, 0);
        axi_write(32'h20, 32'hFFFF_FFFF, 0);
        @(negedge aclk); ext[0] = 1'b0;
        repeat (5) @(negedge aclk);
        chk("edge_irq", {31'b0, interrupt}, 1);
        axi_read(32'h20, 0, d); chk("edge_status", d, 32'h1);
        axi_write(32'h20, 32'h1, 0);
        repeat (2) @(negedge aclk);
        chk("edge_irq_clr", {31'b0, interrupt}, 0);

        ext = ~32'h8;
        repeat (4) @(negedge aclk);
        axi_write(32'h18, 32'h0, 0);
        axi_write(32'h14, 32'h8, 0);
        axi_write(32'h20, 32'hFFFF_FFFF, 0);
        axi_read(32'h20, 0, d); chk("level_status", d, 32'h8);
        repeat (2) @(negedge aclk);
        chk("level_irq", {31'b0, interrupt}, 1);

        axi_read(32'h3C, 0, d); chk("unmapped_rd", d, 0);
        axi_write(32'h3C, 32'hDEAD_BEEF, 0);
        for (int i = 0; i < 9; i++) axi_read(i * 4, 0, d);

        for (int i = 0; i < 80; i++) begin
            op  = $urandom_range(0, 2);
            idx = 4'($urandom_range(0, 9));
            if (idx == 4'h9) idx = 4'hF;
            a = $urandom; a[5:2] = idx; a[1:0] = 2'b00;
            if (op == 0) axi_write(a, $urandom, 0);
            else if (op == 1) axi_read(a, 0, d);
            else begin
                @(negedge aclk); ext = $urandom;
                repeat ($urandom_range(1, 4)) @(negedge aclk);
            end
            chk("rnd_irq", {31'b0, interrupt}, {31'b0, m_irq});
            chk("rnd_dir", gpio_dir, m_dir);
            chk("rnd_out", gpio_out, m_out);
        end

        @(negedge aclk);
        awaddr = 32'h08; wdata = 32'h0; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 32'h08; arvalid = 1'b1;
        t = 0;
        do begin @(negedge aclk); t++; end while (!awready && t < 20);
        chk("abort_aw", {31'b0, awready}, 1);
        chk("abort_ar", {31'b0, arready}, 1);
        aresetn = 1'b0; m_reset();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        repeat (5) begin
            @(negedge aclk);
            chk("abort_bvalid", {31'b0, bvalid}, 0);
            chk("abort_rvalid", {31'b0, rvalid}, 0);
        end
        axi_read(32'h08, 0, d); chk("abort_dir", d, 32'hFFFF_FFFF);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/gpio_axi_lite.md
GPIO_AXI_LITE -- requirements
Module: gpio_axi_lite

Interface
REQ-001 SHALL have parameter P_WIDTH, default 32, range 1..32, number of GPIO lines.
REQ-002 SHALL have port aclk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port aresetn, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have AXI4-Lite write ports:
- s_axi_lite_awaddr in 32
- s_axi_lite_awvalid in 1; s_axi_lite_awready out 1
- s_axi_lite_wdata in 32
- s_axi_lite_wvalid in 1; s_axi_lite_wready out 1
- s_axi_lite_bresp out 2
- s_axi_lite_bvalid out 1; s_axi_lite_bready in 1
REQ-005 SHALL have AXI4-Lite read ports:
- s_axi_lite_araddr in 32
- s_axi_lite_arvalid in 1; s_axi_lite_arready out 1
- s_axi_lite_rdata out 32
- s_axi_lite_rresp out 2
- s_axi_lite_rvalid out 1; s_axi_lite_rready in 1
REQ-006 SHALL have GPIO ports:
- gpio_in in P_WIDTH, pad input
- gpio_out out P_WIDTH, output data
- gpio_dir out P_WIDTH, per bit: 1 = input (tri-state), 0 = output
- interrupt out 1, level, active-high

Function
REQ-007 Register map, decoded on addr[5:2]; bits above P_WIDTH read 0:
- 0x00 VERSION: RO, 0x2025_0910
- 0x04 CONTROL: bit0 IE, global interrupt enable
- 0x08 DIR: drives gpio_dir
- 0x0C OUT: drives gpio_out
- 0x10 IN: RO, synchronized gpio_in
- 0x14 MASK: per-bit interrupt enable
- 0x18 EDGE: 1 = edge-sensitive, 0 = level-sensitive
- 0x1C POL: 1 = rising/high, 0 = falling/low
- 0x20 STATUS: W1C
REQ-008 Unmapped addresses SHALL read 0 and ignore writes; writes to RO registers are ignored; bresp/rresp are always 2'b00 (OKAY). There is no wstrb; every write is a full word.
REQ-009 Write handshake:
- awready and wready assert together for one cycle only when awvalid, wvalid and !bvalid all hold.
- The register updates on that edge.
- bvalid asserts on the next cycle and holds until bready.
REQ-010 Read handshake:
- arready asserts for one cycle when arvalid and !rvalid.
- rdata is captured on that edge; rvalid asserts on the next cycle.
- rdata is held stable until rready.
REQ-011 Read and write channels SHALL operate independently and may complete in the same cycle.
REQ-012 gpio_in SHALL pass through a 2-flop synchronizer. IN reflects a pad change 2 cycles after it, and is readable on the next read.
REQ-013 Event per bit i, computed on the synchronized value s against its previous value p, only when DIR[i]=1:
- EDGE=1, POL=1: s & ~p
- EDGE=1, POL=0: ~s & p
- EDGE=0: s == POL, every cycle
REQ-014 An event SHALL set STATUS[i]. A W1C write clears set bits; if a set and a clear occur in the same cycle, the set wins.
REQ-015 interrupt SHALL be registered as CONTROL.IE & |(STATUS & MASK), one cycle after STATUS changes.

Reset
REQ-016 While aresetn=0:
- DIR = all ones (all inputs)
- OUT, MASK, EDGE, POL, STATUS, CONTROL = 0
- synchronizer flops = 0
- awready, wready, arready, bvalid, rvalid, interrupt = 0
- rdata = 0
REQ-017 Reset asserted mid-transaction SHALL abort it; no response is issued after release.

Structure
REQ-018 Package gpio_axi_lite_pkg SHALL hold the register offsets, VERSION value and RESP_OKAY.
REQ-019 One sub-module, gpio_sync (parameterized-width 2-flop synchronizer); all else is in gpio_axi_lite.

Verification
REQ-020 Reset then read DIR, OUT, IN with pull-ups on the pads -> 0xFFFF_FFFF, 0x0, 0xFFFF_FFFF.
REQ-021 Write DIR=0, write OUT=0xA5A5_5A5A, wait 3 cycles, read IN -> 0xA5A5_5A5A; bresp = 0 on both writes.
REQ-022 Hold bready=0 for 5 cycles after a write -> bvalid stays 1 and awready stays 0. Same test for rready/rvalid/arready.
REQ-023 Edge interrupt:
- Setup: DIR=0xFFFF_FFFF, EDGE=1, POL=0, MASK=0x1, CONTROL=1.
- Drive bit0 low -> interrupt=1, STATUS=0x1.
- Write STATUS=0x1 -> interrupt=0.
REQ-024 Level interrupt: EDGE=0, POL=0, bit3 held low, MASK=0x8 -> after a W1C write of STATUS=0x8, STATUS reads 0x8 again and interrupt stays 1.
REQ-025 Read 0x3C -> 0x0, OKAY; write 0x3C -> no register changes.
